// File: rtl/vga_sync_out.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_sync_out : VGA timing, pixel coordinates and registered sync/colour.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module vga_sync_out #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int SYNC_POL  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic ACTIVE = (SYNC_POL != 0);

  logic [DIV_W-1:0] divider;
  logic [9:0]       h_count;
  logic [9:0]       v_count;
  logic             h_wrap;
  logic             in_hsync;
  logic             in_vsync;

  assign p_tick      = (divider == DIV_W'(CLK_DIV - 1));
  assign h_wrap      = (h_count == 10'(H_TOTAL - 1));
  assign in_hsync    = (h_count >= 10'(HS_START)) && (h_count <= 10'(HS_END));
  assign in_vsync    = (v_count >= 10'(VS_START)) && (v_count <= 10'(VS_END));
  assign video_on    = (h_count < 10'(H_DISPLAY)) && (v_count < 10'(V_DISPLAY));
  assign frame_start = p_tick && (h_count == 10'd0) && (v_count == 10'd0);
  assign pixel_x     = h_count;
  assign pixel_y     = v_count;

  // Output pins capture the pre-advance counter state, so they trail
  // pixel_x/pixel_y by exactly one pixel period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider <= '0;
      h_count <= '0;
      v_count <= '0;
      hsync   <= ~ACTIVE;
      vsync   <= ~ACTIVE;
      rgb_out <= 3'b000;
    end else begin
      if (p_tick) begin
        divider <= '0;
      end else begin
        divider <= divider + DIV_W'(1);
      end
      if (p_tick) begin
        hsync   <= in_hsync ? ACTIVE : ~ACTIVE;
        vsync   <= in_vsync ? ACTIVE : ~ACTIVE;
        rgb_out <= video_on ? rgb_in : 3'b000;
        if (h_wrap) begin
          h_count <= '0;
          v_count <= (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_out.md
Name: vga_sync_out

Overview:
- Display-side end of the pixel colour path: generates VGA 640x480@60 timing from the 50 MHz system clock.
- Publishes the current pixel coordinates and the active-video flag to the object generators and the colour multiplexer.
- Samples the 3-bit colour returned for that pixel and drives the registered hsync/vsync/rgb pins, blanking colour outside the visible area.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- rgb_in  input  3  colour for the pixel at pixel_x/pixel_y ({b,g,r} bit order, bit0 = red)
- p_tick  output  1  one-clk pulse per pixel period
- pixel_x  output  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  output  10  current vertical count, 0..V_TOTAL-1
- video_on  output  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
- frame_start  output  1  one-clk pulse coincident with p_tick when pixel_x=0, pixel_y=0
- hsync  output  1  registered horizontal sync
- vsync  output  1  registered vertical sync
- rgb_out  output  3  registered, blanked colour to DAC pins

Behaviour:
- Derived totals: H_TOTAL = sum of H_*, giving 800; V_TOTAL = sum of V_*, giving 525.
- Clock, reset and reset values:
  - Single clock domain (clk). Reset is asynchronous and active-high.
  - On reset: divider=0, h_count=0, v_count=0, hsync=vsync=~SYNC_POL (inactive), rgb_out=3'b000.
  - Reset may assert mid-line or mid-frame. It forces all of the above immediately. The first p_tick after release occurs CLK_DIV clks later.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1, then wraps.
  - p_tick=1 on the clk where divider==CLK_DIV-1.
  - CLK_DIV=1 means p_tick is constantly 1 after reset.
- Counters:
  - Advance only on p_tick.
  - h_count wraps from H_TOTAL-1 to 0.
  - v_count increments only when h_count wraps, and wraps from V_TOTAL-1 to 0 in that same tick (simultaneous wrap yields 0,0).
  - pixel_x and pixel_y are the counter registers directly. They are stable for the whole pixel period.
- Combinational outputs:
  - video_on and frame_start are combinational from the counters (frame_start is also gated by p_tick).
  - Sync regions:
    - h-sync region: H_DISPLAY+H_FRONT <= h_count <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
    - v-sync region: V_DISPLAY+V_FRONT <= v_count <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- Output register stage (updates on p_tick only; holds otherwise):
  - hsync <= SYNC_POL when in the h-sync region, else ~SYNC_POL. vsync follows the same rule with the v-sync region.
  - rgb_out <= video_on ? rgb_in : 3'b000.
  - The values captured are for the counter state before the advance. hsync, vsync and rgb_out therefore lag pixel_x/pixel_y by exactly one pixel period, and stay mutually aligned.
- Consumer contract: rgb_in must be valid combinationally from pixel_x/pixel_y before the clk edge where p_tick=1. The block does not sample rgb_in at any other time.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 840000 clks at defaults.

Test Plan:
- Reset release: hold reset 5 clks, release.
  - Required during reset: hsync=vsync=1, rgb_out=0, pixel_x=pixel_y=0.
  - Required after release: first p_tick on clk 2; pixel_x=1 after it.
- Line timing: run 2 lines.
  - hsync low for exactly 96 pixel periods, i.e. 192 clks.
  - hsync falls one pixel after pixel_x=656 is presented.
  - Line period is 1600 clks.
- Frame timing: run 1 full frame.
  - vsync low for exactly 2 lines (3200 clks), starting one pixel after pixel_y=490, pixel_x=0.
  - frame_start pulses exactly once per 840000 clks.
- Blanking: drive rgb_in=3'b111 constantly.
  - rgb_out=3'b111 for 640 pixels per visible line, 0 for the remaining 160 pixels.
  - rgb_out=0 on all lines 480..524.
- Colour alignment: drive rgb_in = pixel_x[2:0].
  - rgb_out shows value k one pixel period after pixel_x=k, for every k<640.
- Mid-frame reset: assert reset at pixel_y=300, pixel_x=400, for 1 clk.
  - Counters read 0,0 and rgb_out=0 on the next clk.
  - Timing then restarts: next vsync pulse begins at line 490 of the new frame.
